// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: valid/ack handshake to a variable-latency memory, stalling the pipeline until done.
// Accept takes one cycle, then up to MAX_WAIT WAIT cycles, then one DONE cycle; Stall holds upstream for accept and WAIT.
module mem_access_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        InstValid,
    input  logic [3:0]  Opcode,
    input  logic [15:0] MemAddr,
    input  logic [15:0] StoreData,
    output logic        Stall,
    output logic [15:0] LoadData,
    output logic        LoadValid,
    output logic        MemErr,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        en_q, en_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] ld_q, ld_d;
    logic        lv_q, lv_d;
    logic        err_q, err_d;
    logic        stall_c;
    logic        memop;

    assign memop = InstValid && (Opcode == 4'b1000 || Opcode == 4'b1001);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        lv_d    = 1'b0;
        err_d   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    if (MemAddr[0]) begin
                        err_d = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        en_d    = 1'b1;
                        wr_d    = Opcode[0];
                        addr_d  = MemAddr;
                        wdata_d = StoreData;
                        cnt_d   = 8'd0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                // An ack in the final wait cycle still counts as success.
                if (mem_ack) begin
                    en_d    = 1'b0;
                    state_d = DONE;
                    if (!wr_q) begin
                        ld_d = mem_rdata;
                        lv_d = 1'b1;
                    end
                end else if (cnt_q == LAST_WAIT) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (!wr_q) begin
                        ld_d = 16'h0000;
                        lv_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                // Inputs still show the completed instruction, so no accept here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            ld_q    <= 16'h0000;
            lv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            lv_q    <= lv_d;
            err_q   <= err_d;
        end
    end

    // Stall is combinational, so it must also be forced low while reset is held.
    assign Stall     = stall_c && !rst;
    assign LoadData  = ld_q;
    assign LoadValid = lv_q;
    assign MemErr    = err_q;
    assign mem_en    = en_q;
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, async-reset sequence, then randomized ops
// checked against a transaction-level prediction of stall length, handshake and load results.
module tb_mem_access_ctrl;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        InstValid;
    logic [3:0]  Opcode;
    logic [15:0] MemAddr;
    logic [15:0] StoreData;
    logic        Stall;
    logic [15:0] LoadData;
    logic        LoadValid;
    logic        MemErr;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] model_ld;

    typedef struct {
        logic        iv;
        logic [3:0]  op;
        logic [15:0] addr;
        logic [15:0] wdat;
        int          ack_at;   // ack in this WAIT cycle (1-based); 0 or >MAXW means never
        logic [15:0] rdat;
        bit          tail;     // append an idle cycle after the instruction
        int          e_stall;
        int          e_en;
        int          e_lv;
        int          e_err;
        logic [15:0] e_ld;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    mem_access_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .InstValid (InstValid),
        .Opcode    (Opcode),
        .MemAddr   (MemAddr),
        .StoreData (StoreData),
        .Stall     (Stall),
        .LoadData  (LoadData),
        .LoadValid (LoadValid),
        .MemErr    (MemErr),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic vec_t mk(input logic iv, input logic [3:0] op, input logic [15:0] addr,
                                input logic [15:0] wdat, input int ack_at, input logic [15:0] rdat,
                                input bit tail, input int e_stall, input int e_en, input int e_lv,
                                input int e_err, input logic [15:0] e_ld);
        vec_t v;
        v.iv = iv; v.op = op; v.addr = addr; v.wdat = wdat; v.ack_at = ack_at; v.rdat = rdat;
        v.tail = tail; v.e_stall = e_stall; v.e_en = e_en; v.e_lv = e_lv; v.e_err = e_err;
        v.e_ld = e_ld;
        return v;
    endfunction

    // Runs one instruction through MEM, acting as the memory, and checks the observed totals.
    task automatic run_op(input string tag, input vec_t v);
        int stall_n = 0;
        int en_n    = 0;
        int lv_n    = 0;
        int err_n   = 0;
        int bad     = 0;
        int cyc     = 0;
        bit done    = 0;
        while (!done && cyc < MAXW + 4) begin
            @(negedge clk);
            if (cyc == 0) begin
                InstValid = v.iv;
                Opcode    = v.op;
                MemAddr   = v.addr;
                StoreData = v.wdat;
            end
            if (mem_en) begin
                mem_ack   = (en_n + 1 == v.ack_at);
                mem_rdata = mem_ack ? v.rdat : 16'($urandom);
            end else begin
                mem_ack   = 1'($urandom);
                mem_rdata = 16'($urandom);
            end
            #1;
            if (Stall) stall_n++;
            else done = 1;
            if (mem_en) begin
                en_n++;
                if (mem_addr !== v.addr || mem_wr !== v.op[0] || (v.op[0] && mem_wdata !== v.wdat))
                    bad++;
            end
            lv_n  += int'(LoadValid);
            err_n += int'(MemErr);
            cyc++;
        end
        chk({tag, " completes"}, int'(done), 1);
        if (v.tail) begin
            @(negedge clk);
            InstValid = 1'b0;
            Opcode    = 4'($urandom);
            MemAddr   = 16'($urandom);
            mem_ack   = 1'($urandom);
            mem_rdata = 16'($urandom);
            #1;
            lv_n  += int'(LoadValid);
            err_n += int'(MemErr);
            if (mem_en) en_n++;
        end
        mem_ack = 1'b0;
        chk({tag, " stall_cycles"}, stall_n, v.e_stall);
        chk({tag, " mem_en_cycles"}, en_n, v.e_en);
        chk({tag, " req_attr_bad"}, bad, 0);
        chk({tag, " loadvalid_pulses"}, lv_n, v.e_lv);
        chk({tag, " memerr_pulses"}, err_n, v.e_err);
        chk({tag, " loaddata"}, int'(LoadData), int'(v.e_ld));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        bit memop, acc, acked;
        int late_bad;

        // Directed vectors; expectations derived by hand for MAX_WAIT = 8.
        vecs[0]  = mk(1, 4'b1000, 16'h0010, 16'h0000, 3, 16'hBEEF, 1, 4, 3, 1, 0, 16'hBEEF);
        vecs[1]  = mk(1, 4'b1001, 16'h0042, 16'h1234, 1, 16'h5555, 1, 2, 1, 0, 0, 16'hBEEF);
        vecs[2]  = mk(1, 4'b1000, 16'h0011, 16'h0000, 1, 16'h7777, 1, 0, 0, 0, 1, 16'hBEEF);
        vecs[3]  = mk(1, 4'b1000, 16'h0020, 16'h0000, 0, 16'h0000, 1, 9, 8, 1, 1, 16'h0000);
        vecs[4]  = mk(1, 4'b1000, 16'h0020, 16'h0000, 8, 16'hCAFE, 1, 9, 8, 1, 0, 16'hCAFE);
        vecs[5]  = mk(1, 4'b0011, 16'h0030, 16'h0000, 1, 16'h0000, 1, 0, 0, 0, 0, 16'hCAFE);
        vecs[6]  = mk(0, 4'b1000, 16'h0030, 16'h0000, 1, 16'h0000, 1, 0, 0, 0, 0, 16'hCAFE);
        vecs[7]  = mk(1, 4'b1001, 16'h0043, 16'h9999, 1, 16'h0000, 1, 0, 0, 0, 1, 16'hCAFE);
        vecs[8]  = mk(1, 4'b1000, 16'h0100, 16'h0000, 2, 16'h1111, 0, 3, 2, 1, 0, 16'h1111);
        vecs[9]  = mk(1, 4'b1001, 16'h0102, 16'h2222, 2, 16'h3333, 1, 3, 2, 0, 0, 16'h1111);
        vecs[10] = mk(1, 4'b1001, 16'h0004, 16'h4444, 0, 16'h0000, 1, 9, 8, 0, 1, 16'h1111);

        rst = 1'b1; InstValid = 1'b0; Opcode = 4'h0; MemAddr = 16'h0; StoreData = 16'h0;
        mem_ack = 1'b0; mem_rdata = 16'h0;
        #12;
        chk("reset mem_en", int'(mem_en), 0);
        chk("reset Stall", int'(Stall), 0);
        chk("reset LoadData", int'(LoadData), 0);
        chk("reset pulses", int'({LoadValid, MemErr, mem_wr}), 0);
        chk("reset mem_addr_wdata", int'({mem_addr, mem_wdata}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        // Asynchronous reset in the middle of a WAIT, followed by a late ack.
        @(negedge clk);
        InstValid = 1'b1; Opcode = 4'b1000; MemAddr = 16'h0050; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midwait mem_en", int'(mem_en), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst mem_en", int'(mem_en), 0);
        chk("async rst Stall", int'(Stall), 0);
        chk("async rst LoadData", int'(LoadData), 0);
        @(negedge clk);
        rst = 1'b0; InstValid = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        late_bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (mem_en || LoadValid || MemErr || Stall) late_bad++;
        end
        chk("late ack ignored", late_bad, 0);
        chk("late ack LoadData", int'(LoadData), 0);
        mem_ack = 1'b0;
        model_ld = 16'h0000;

        // Randomized ops against a transaction-level prediction.
        for (int i = 0; i < 40; i++) begin
            rv.iv     = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 4))
                0, 1:    rv.op = 4'b1000;
                2, 3:    rv.op = 4'b1001;
                default: rv.op = 4'($urandom);
            endcase
            rv.addr   = 16'($urandom);
            if ($urandom_range(0, 3) != 0) rv.addr[0] = 1'b0;
            rv.wdat   = 16'($urandom);
            rv.rdat   = 16'($urandom);
            rv.ack_at = $urandom_range(0, MAXW + 2);
            memop = rv.iv && (rv.op == 4'b1000 || rv.op == 4'b1001);
            acc   = memop && !rv.addr[0];
            acked = acc && rv.ack_at >= 1 && rv.ack_at <= MAXW;
            rv.tail    = acc ? bit'($urandom_range(0, 1)) : 1'b1;
            rv.e_en    = acc ? (acked ? rv.ack_at : MAXW) : 0;
            rv.e_stall = acc ? rv.e_en + 1 : 0;
            rv.e_lv    = (acc && !rv.op[0]) ? 1 : 0;
            rv.e_err   = ((memop && rv.addr[0]) || (acc && !acked)) ? 1 : 0;
            if (acc && !rv.op[0]) model_ld = acked ? rv.rdat : 16'h0000;
            rv.e_ld    = model_ld;
            run_op($sformatf("rnd%0d", i), rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
